// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Frame: 16-bit word count, big-endian payload words, XOR checksum byte.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int CSUM_W         = 8;

  function automatic logic takes_bytes(state_e s);
    return s inside {S_HDR_HI, S_HDR_LO, S_DATA, S_CHECK};
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Big-endian byte-to-word packer; word/word_valid present the full word
// in the same cycle its last byte is accepted.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] shift_q, shift_d;

  assign word       = {shift_q, byte_in};
  assign word_valid = byte_en && (byte_idx_q == LAST);

  always_comb begin
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    if (clr) begin
      byte_idx_d = '0;
      shift_d    = '0;
    end else if (byte_en) begin
      byte_idx_d = byte_idx_q + 2'd1;
      shift_d    = {shift_q[15:0], byte_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx_q <= '0;
      shift_q    <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads instruction memory from a byte stream, checks the XOR checksum,
// and only then releases the core from reset.
module imem_boot_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst_n,
  output logic        done,
  output logic        error
);

  state_e state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] idx_q, idx_d;
  logic [CSUM_W-1:0] csum_q, csum_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        run_q, run_d;

  logic        take;
  logic        asm_clr, asm_en, asm_valid;
  logic [31:0] asm_word;
  logic [15:0] cnt;
  logic [15:0] idx_inc;

  assign take    = s_valid && ready_q;
  assign idx_inc = idx_q + 16'd1;

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (asm_clr),
    .byte_en    (asm_en),
    .byte_in    (s_data),
    .word_valid (asm_valid),
    .word       (asm_word)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    asm_clr = 1'b0;
    asm_en  = 1'b0;
    cnt     = {hi_q, s_data};
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR_HI;
          csum_d  = '0;
          asm_clr = 1'b1;
        end
      end
      S_HDR_HI: begin
        if (take) begin
          hi_d    = s_data;
          state_d = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (take) begin
          count_d = cnt;
          idx_d   = '0;
          asm_clr = 1'b1;
          if (cnt == 16'd0 || 32'(cnt) > 32'(MAX_WORDS))
            state_d = S_ERR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        asm_en = take;
        if (take) begin
          csum_d = csum_q ^ s_data;
          if (asm_valid) begin
            we_d    = 1'b1;
            addr_d  = BASE_ADDR + {14'd0, idx_q, 2'b00};
            wdata_d = asm_word;
            idx_d   = idx_inc;
            if (idx_inc == count_q) state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (take)
          state_d = (s_data == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = takes_bytes(state_d);
    done_d  = (state_d == S_DONE);
    err_d   = (state_d == S_ERR);
    run_d   = done_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      hi_q    <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      run_q   <= run_d;
    end
  end

  assign s_ready    = ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst_n  = run_q;
  assign done       = done_q;
  assign error      = err_q;

endmodule
